// File: rtl/mix_columns_iter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : mix_columns_iter (with mix_columns_gf_pkg)
//  Function : Iterative AES MixColumns / InvMixColumns over a 128-bit state,
//             COLS_PER_CYCLE columns per busy cycle, valid/ready on both sides.
//  Revision : 1.0  initial release
// ============================================================================

package mix_columns_gf_pkg;

  // Multiply by x modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul2(input logic [7:0] a);
    return gf_xtime(a);
  endfunction

  function automatic logic [7:0] gf_mul3(input logic [7:0] a);
    return gf_xtime(a) ^ a;
  endfunction

  function automatic logic [7:0] gf_mul9(input logic [7:0] a);
    return gf_xtime(gf_xtime(gf_xtime(a))) ^ a;
  endfunction

  function automatic logic [7:0] gf_mul11(input logic [7:0] a);
    logic [7:0] x2;
    x2 = gf_xtime(a);
    return gf_xtime(gf_xtime(x2)) ^ x2 ^ a;
  endfunction

  function automatic logic [7:0] gf_mul13(input logic [7:0] a);
    logic [7:0] x4;
    x4 = gf_xtime(gf_xtime(a));
    return gf_xtime(x4) ^ x4 ^ a;
  endfunction

  function automatic logic [7:0] gf_mul14(input logic [7:0] a);
    logic [7:0] x2;
    logic [7:0] x4;
    x2 = gf_xtime(a);
    x4 = gf_xtime(x2);
    return gf_xtime(x4) ^ x4 ^ x2;
  endfunction

  // Column words carry b0 in the most significant byte
  function automatic logic [31:0] mix_col_enc(input logic [31:0] c);
    logic [7:0] b0, b1, b2, b3;
    {b0, b1, b2, b3} = c;
    return {gf_mul2(b0) ^ gf_mul3(b1) ^ b2          ^ b3,
            b0          ^ gf_mul2(b1) ^ gf_mul3(b2) ^ b3,
            b0          ^ b1          ^ gf_mul2(b2) ^ gf_mul3(b3),
            gf_mul3(b0) ^ b1          ^ b2          ^ gf_mul2(b3)};
  endfunction

  function automatic logic [31:0] mix_col_dec(input logic [31:0] c);
    logic [7:0] b0, b1, b2, b3;
    {b0, b1, b2, b3} = c;
    return {gf_mul14(b0) ^ gf_mul11(b1) ^ gf_mul13(b2) ^ gf_mul9(b3),
            gf_mul9(b0)  ^ gf_mul14(b1) ^ gf_mul11(b2) ^ gf_mul13(b3),
            gf_mul13(b0) ^ gf_mul9(b1)  ^ gf_mul14(b2) ^ gf_mul11(b3),
            gf_mul11(b0) ^ gf_mul13(b1) ^ gf_mul9(b2)  ^ gf_mul14(b3)};
  endfunction

endpackage

module mix_columns_iter #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [127:0] s_i,
  input  logic         op_i,
  input  logic         bypass_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [127:0] s_o
);

  import mix_columns_gf_pkg::*;

  // Counter wraps modulo 4, so a step of 4 truncates to 0 and never advances
  localparam logic [1:0] STEP     = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST_CNT = 2'(4 - COLS_PER_CYCLE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [1:0]     cnt_q, cnt_d;
  logic [127:0]   st_q, st_d;
  logic           op_q, op_d;
  logic           byp_q, byp_d;
  logic           init_q;
  logic           accept;

  logic [1:0]     col_idx [COLS_PER_CYCLE];
  logic [31:0]    col_in  [COLS_PER_CYCLE];
  logic [31:0]    col_out [COLS_PER_CYCLE];

  // init_q holds in_ready_o low while in reset and until the first edge after release
  assign in_ready_o  = init_q & ((state_q == IDLE) | ((state_q == DONE) & out_ready_i));
  assign accept      = in_valid_i & in_ready_o;
  assign out_valid_o = (state_q == DONE);
  assign s_o         = st_q;

  for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_col
    assign col_idx[k] = cnt_q + 2'(k);
    // Column c sits at bits [127-32c -: 32]; ~c equals 3-c for a 2-bit index
    assign col_in[k]  = st_q[{~col_idx[k], 5'b0} +: 32];
    assign col_out[k] = byp_q ? col_in[k] :
                        (op_q ? mix_col_enc(col_in[k]) : mix_col_dec(col_in[k]));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      st_q   <= '0;
      op_q   <= 1'b1;
      byp_q  <= 1'b0;
      init_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      st_q   <= st_d;
      op_q   <= op_d;
      byp_q  <= byp_d;
      init_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    st_d    = st_q;
    op_d    = op_q;
    byp_d   = byp_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = BUSY;
          cnt_d   = '0;
          st_d    = s_i;
          op_d    = op_i;
          byp_d   = bypass_i;
        end
      end

      BUSY: begin
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
          st_d[{~col_idx[k], 5'b0} +: 32] = col_out[k];
        end
        cnt_d = cnt_q + STEP;
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
        end
      end

      DONE: begin
        if (accept) begin
          state_d = BUSY;
          cnt_d   = '0;
          st_d    = s_i;
          op_d    = op_i;
          byp_d   = bypass_i;
        end else if (out_ready_i) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_mix_columns_iter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_mix_columns_iter
//  Function : Directed and randomized checks of mix_columns_iter for
//             COLS_PER_CYCLE = 1, 2 and 4 (one instance each).
//  Revision : 1.0  initial release
// ============================================================================

module tb_mix_columns_iter;

  localparam logic [127:0] KAT_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] KAT_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [2:0]       in_valid;
  logic [2:0]       in_ready;
  logic [2:0]       op_in;
  logic [2:0]       byp_in;
  logic [2:0]       out_valid;
  logic [2:0]       out_ready;
  logic [2:0][127:0] s_in;
  logic [2:0][127:0] s_out;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mix_columns_iter #(.COLS_PER_CYCLE(1 << g)) u_dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .in_valid_i (in_valid[g]),
      .in_ready_o (in_ready[g]),
      .s_i        (s_in[g]),
      .op_i       (op_in[g]),
      .bypass_i   (byp_in[g]),
      .out_valid_o(out_valid[g]),
      .out_ready_i(out_ready[g]),
      .s_o        (s_out[g])
    );
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Shift-and-add GF(2^8) multiply, independent of the xtime chains in the design
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int n = 0; n < 8; n++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] mix_ref(input logic [127:0] s, input logic op, input logic byp);
    logic [7:0]   enc_row [4];
    logic [7:0]   dec_row [4];
    logic [7:0]   acc;
    logic [127:0] r;
    enc_row = '{8'd2, 8'd3, 8'd1, 8'd1};
    dec_row = '{8'd14, 8'd11, 8'd13, 8'd9};
    if (byp) return s;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) begin
          acc = acc ^ gmul(op ? enc_row[(j - row + 4) % 4] : dec_row[(j - row + 4) % 4],
                           s[8*(15-(4*c+j)) +: 8]);
        end
        r[8*(15-(4*c+row)) +: 8] = acc;
      end
    end
    return r;
  endfunction

  // Presents one state and returns #1 after the accept edge with operands scrambled
  task automatic send(input int i, input logic [127:0] s, input logic op, input logic byp);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready[i] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready[i]) check_eq($sformatf("ready_timeout_c%0d", 1 << i), 128'(in_ready[i]), 128'd1);
    in_valid[i] = 1'b1;
    s_in[i]     = s;
    op_in[i]    = op;
    byp_in[i]   = byp;
    @(posedge clk);
    #1;
    in_valid[i] = 1'b0;
    s_in[i]     = ~s;
    op_in[i]    = ~op;
    byp_in[i]   = ~byp;
  endtask

  // Counts edges from the accept edge (inclusive) to the first sample with out_valid high
  task automatic wait_done(input int i, output int lat);
    lat = 1;
    @(negedge clk);
    while (!out_valid[i] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid[i]) check_eq($sformatf("done_timeout_c%0d", 1 << i), 128'(out_valid[i]), 128'd1);
  endtask

  task automatic consume(input int i);
    out_ready[i] = 1'b1;
    #1;
    check_eq($sformatf("done_ready_c%0d", 1 << i), 128'(in_ready[i]), 128'd1);
    @(posedge clk);
    #1;
    out_ready[i] = 1'b0;
    check_eq($sformatf("no_dup_c%0d", 1 << i), 128'(out_valid[i]), 128'd0);
  endtask

  task automatic run_one(input int i, input string tag, input logic [127:0] s,
                         input logic op, input logic byp, input logic [127:0] exp);
    int lat;
    send(i, s, op, byp);
    wait_done(i, lat);
    check_eq($sformatf("%s_data_c%0d", tag, 1 << i), s_out[i], exp);
    check_eq($sformatf("%s_lat_c%0d", tag, 1 << i), 128'(lat), 128'((4 >> i) + 1));
    consume(i);
  endtask

  task automatic stall_b2b(input int i);
    int lat;
    int bad;
    logic [127:0] held;
    send(i, KAT_IN, 1'b1, 1'b0);
    wait_done(i, lat);
    held = s_out[i];
    bad  = 0;
    repeat (10) begin
      @(negedge clk);
      if (s_out[i] !== held || out_valid[i] !== 1'b1 || in_ready[i] !== 1'b0) bad++;
    end
    check_eq($sformatf("stall_stable_c%0d", 1 << i), 128'(bad), 128'd0);
    check_eq($sformatf("stall_data_c%0d", 1 << i), held, KAT_OUT);
    out_ready[i] = 1'b1;
    in_valid[i]  = 1'b1;
    s_in[i]      = KAT_OUT;
    op_in[i]     = 1'b0;
    byp_in[i]    = 1'b0;
    #1;
    check_eq($sformatf("b2b_ready_c%0d", 1 << i), 128'(in_ready[i]), 128'd1);
    @(posedge clk);
    #1;
    in_valid[i]  = 1'b0;
    out_ready[i] = 1'b0;
    op_in[i]     = 1'b1;
    // Straight into BUSY: neither valid nor ready may be high the cycle after
    check_eq($sformatf("b2b_busy_c%0d", 1 << i), 128'({in_ready[i], out_valid[i]}), 128'd0);
    wait_done(i, lat);
    check_eq($sformatf("b2b_lat_c%0d", 1 << i), 128'(lat), 128'((4 >> i) + 1));
    check_eq($sformatf("b2b_data_c%0d", 1 << i), s_out[i], KAT_IN);
    consume(i);
  endtask

  task automatic reset_mid_busy(input int i);
    int stale;
    send(i, KAT_IN, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq($sformatf("rst_valid_c%0d", 1 << i), 128'(out_valid[i]), 128'd0);
    check_eq($sformatf("rst_sout_c%0d", 1 << i), s_out[i], 128'd0);
    check_eq($sformatf("rst_ready_c%0d", 1 << i), 128'(in_ready[i]), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid[i] !== 1'b0) stale++;
    end
    check_eq($sformatf("rst_no_stale_c%0d", 1 << i), 128'(stale), 128'd0);
    run_one(i, "post_rst", KAT_IN, 1'b1, 1'b0, KAT_OUT);
  endtask

  task automatic random_run(input int i, input int count);
    int lat;
    logic [127:0] s;
    logic op, byp;
    for (int n = 0; n < count; n++) begin
      s   = {$urandom, $urandom, $urandom, $urandom};
      op  = 1'($urandom);
      byp = ($urandom_range(0, 7) == 0);
      send(i, s, op, byp);
      wait_done(i, lat);
      check_eq($sformatf("rnd_lat_c%0d_%0d", 1 << i, n), 128'(lat), 128'((4 >> i) + 1));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      check_eq($sformatf("rnd_data_c%0d_%0d", 1 << i, n), s_out[i], mix_ref(s, op, byp));
      consume(i);
    end
  endtask

  initial begin
    logic [127:0] rs;
    rst_n     = 1'b0;
    in_valid  = '0;
    op_in     = '0;
    byp_in    = '0;
    out_ready = '0;
    s_in      = '0;
    #3;
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("reset_ready_c%0d", 1 << i), 128'(in_ready[i]), 128'd0);
      check_eq($sformatf("reset_valid_c%0d", 1 << i), 128'(out_valid[i]), 128'd0);
      check_eq($sformatf("reset_sout_c%0d", 1 << i), s_out[i], 128'd0);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("ready_before_edge", 128'(in_ready), 128'd0);
    @(negedge clk);
    check_eq("ready_after_edge", 128'(in_ready), 128'h7);

    // Reference model sanity against the published column vector
    check_eq("ref_model_kat", mix_ref(KAT_IN, 1'b1, 1'b0), KAT_OUT);

    for (int i = 0; i < 3; i++) begin
      run_one(i, "enc_kat", KAT_IN, 1'b1, 1'b0, KAT_OUT);
      run_one(i, "dec_kat", KAT_OUT, 1'b0, 1'b0, KAT_IN);
      rs = {$urandom, $urandom, $urandom, $urandom};
      run_one(i, "bypass", rs, 1'($urandom), 1'b1, rs);
      stall_b2b(i);
      reset_mid_busy(i);
      random_run(i, 1000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
